// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the IF-stage PC generator: PC width, branch opcode
// and the fetch FSM state encoding.
package fetch_pc_unit_pkg;

    localparam int PC_W = 64;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } fetch_state_t;

    function automatic logic is_branch(input logic [6:0] opcode);
        return opcode == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_sat.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator: next-PC selection, IF/ID prediction record and
// ID-stage misprediction detection with flush and perf counters.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             stall,
    input  logic             bpt_taken,
    input  logic [PC_W-1:0]  bpt_target,
    input  logic [31:0]      ID_INST,
    input  logic             id_branch_taken,
    input  logic [PC_W-1:0]  id_branch_target,
    output logic [PC_W-1:0]  IF_PC,
    output logic [PC_W-1:0]  ID_PC,
    output logic             id_valid,
    output logic             flush_if,
    output logic             notFlushed,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output fetch_state_t     fsm_state
);

    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            is_br;
    logic            eval;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] next_pc;
    logic            unused_inst;

    assign unused_inst = ^ID_INST[31:7];

    always_comb begin
        is_br      = is_branch(ID_INST[6:0]);
        eval       = (fsm_state == RUN) && id_valid && !stall;
        mispredict = 1'b0;
        if (eval) begin
            // A non-branch that the BPT aliased as taken also steered fetch wrongly.
            if (is_br) begin
                mispredict = (pred_taken != id_branch_taken) ||
                             (id_branch_taken && (pred_target != id_branch_target));
            end else begin
                mispredict = pred_taken;
            end
        end

        redirect_pc = (is_br && id_branch_taken) ? id_branch_target : ID_PC + 64'd4;

        if (fsm_state == BOOT) begin
            next_pc = RESET_PC;
        end else if (mispredict) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = IF_PC;
        end else if (bpt_taken) begin
            next_pc = bpt_target;
        end else begin
            next_pc = IF_PC + 64'd4;
        end
    end

    assign flush_if   = mispredict;
    assign notFlushed = ~mispredict;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fsm_state   <= BOOT;
            IF_PC       <= RESET_PC;
            ID_PC       <= '0;
            id_valid    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            case (fsm_state)
                BOOT:    fsm_state <= RUN;
                RUN:     fsm_state <= mispredict ? RECOVER : RUN;
                RECOVER: fsm_state <= RUN;
                default: fsm_state <= BOOT;
            endcase

            IF_PC <= next_pc;

            if (!stall) begin
                ID_PC       <= IF_PC;
                pred_taken  <= bpt_taken;
                pred_target <= bpt_target;
                id_valid    <= !(mispredict || (fsm_state == BOOT));
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (eval && is_br),
        .count  (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (mispredict),
        .count  (mispred_cnt)
    );

endmodule
